// File: rtl/rst_seq_ctrl_if.sv
// Request/status bundle of the reset sequencer: software and watchdog inputs, sequenced resets out.
interface rst_seq_ctrl_if #(parameter int N_OUT = 3);
  logic             sw_rst_req;
  logic             wdog_kick;
  logic [N_OUT-1:0] reset_out;
  logic             seq_done;
  logic [1:0]       rst_cause;

  modport master (output sw_rst_req, wdog_kick, input reset_out, seq_done, rst_cause);
  modport slave  (input sw_rst_req, wdog_kick, output reset_out, seq_done, rst_cause);
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset synchroniser and sequencer: async assert, sync release, staggered per-output release.
// Define RSTSEQ_WDOG_EN to build the watchdog that re-runs the sequence when kicks stop.
module rst_seq_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int N_OUT       = 3,
  parameter int MIN_ASSERT  = 4,
  parameter int RELEASE_GAP = 8,
  parameter int WDOG_CYCLES = 65536
) (
  input  logic          clk,
  input  logic          reset_in,
  rst_seq_ctrl_if.slave bus
);
  localparam int SW_ASSERT = (MIN_ASSERT > 1) ? MIN_ASSERT : 1;
  localparam int CNT_MAX   = (SW_ASSERT > RELEASE_GAP) ? SW_ASSERT : RELEASE_GAP;
  localparam int CW        = $clog2(CNT_MAX) + 1;
  localparam int IW        = $clog2(N_OUT) + 1;

  typedef enum logic [1:0] {S_ASSERT, S_HOLD, S_RELEASE, S_RUN} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-2:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [N_OUT-1:0]       rout_q, rout_d;
  logic                   done_q, done_d;
  logic [1:0]             cause_q, cause_d;
  logic                   step;
  logic                   wdog_fire;

  // The FSM state register is the last synchroniser stage, so only SYNC_STAGES-1 flops live here.
  if (SYNC_STAGES > 2) begin : g_chain
    always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) sync_q <= '0;
      else           sync_q <= {sync_q[SYNC_STAGES-3:0], 1'b1};
    end
  end else begin : g_single
    always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) sync_q <= '0;
      else           sync_q <= 1'b1;
    end
  end

`ifdef RSTSEQ_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES) + 1;
  logic [WW-1:0] wdog_q, wdog_d;

  // Counter idles at zero outside RUN, so re-entering RUN always starts a full timeout.
  always_comb begin
    wdog_d    = '0;
    wdog_fire = 1'b0;
    if (state_q == S_RUN && !bus.wdog_kick) begin
      if (wdog_q == WW'(WDOG_CYCLES - 1)) wdog_fire = 1'b1;
      else                                wdog_d    = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) wdog_q <= '0;
    else           wdog_q <= wdog_d;
  end
`else
  wire unused_kick = bus.wdog_kick;
  assign wdog_fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rout_d  = rout_q;
    done_d  = done_q;
    cause_d = cause_q;
    step    = 1'b0;
    case (state_q)
      S_ASSERT: if (sync_q[SYNC_STAGES-2]) begin
        if (MIN_ASSERT == 0) step = 1'b1;
        else begin
          state_d = S_HOLD;
          cnt_d   = CW'(MIN_ASSERT);
        end
      end
      S_HOLD, S_RELEASE: begin
        if (cnt_q == CW'(1)) step  = 1'b1;
        else                 cnt_d = cnt_q - 1'b1;
      end
      default: ;
    endcase
    // step releases output idx_q and reloads the gap to the next one
    if (step) begin
      rout_d = rout_q | (N_OUT'(1) << idx_q);
      idx_d  = idx_q + 1'b1;
      cnt_d  = CW'(RELEASE_GAP);
      if (idx_q == IW'(N_OUT - 1)) begin
        state_d = S_RUN;
        done_d  = 1'b1;
      end else begin
        state_d = S_RELEASE;
      end
    end
    if (state_q != S_ASSERT && (bus.sw_rst_req || wdog_fire)) begin
      state_d = S_HOLD;
      cnt_d   = CW'(SW_ASSERT);
      idx_d   = '0;
      rout_d  = '0;
      done_d  = 1'b0;
      cause_d = bus.sw_rst_req ? 2'b10 : 2'b11;
    end
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= S_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      rout_q  <= '0;
      done_q  <= 1'b0;
      cause_q <= 2'b01;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rout_q  <= rout_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  assign bus.reset_out = rout_q;
  assign bus.seq_done  = done_q;
  assign bus.rst_cause = cause_q;
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: default-parameter instance A and minimal instance B against an edge-arithmetic model.
module tb_rst_seq_ctrl;
  localparam int S  = 2;
  localparam int NA = 3, MA = 4, GA = 8, WA = 16;
  localparam int NB = 1, MB = 0, GB = 8, WB = 65536;
  localparam int PN [2] = '{NA, NB};
  localparam int PM [2] = '{MA, MB};
  localparam int PG [2] = '{GA, GB};
  localparam int PW [2] = '{WA, WB};
`ifdef RSTSEQ_WDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic ra, rb;
  int   checks = 0, errors = 0;
  int   drop_a = 0, drop_b = 0, seen_a = 0, seen_b = 0;

  // model state: edge count, consecutive high samples, bit-0 release edge, last kick, cause
  int e     [2] = '{0, 0};
  int hi    [2] = '{0, 0};
  int rel   [2] = '{-1, -1};
  int lastk [2] = '{-1, -1};
  int cause [2] = '{1, 1};

  rst_seq_ctrl_if #(.N_OUT(NA)) ifa ();
  rst_seq_ctrl_if #(.N_OUT(NB)) ifb ();

  rst_seq_ctrl #(.SYNC_STAGES(S), .N_OUT(NA), .MIN_ASSERT(MA), .RELEASE_GAP(GA), .WDOG_CYCLES(WA))
    dut_a (.clk(clk), .reset_in(ra), .bus(ifa.slave));
  rst_seq_ctrl #(.SYNC_STAGES(S), .N_OUT(NB), .MIN_ASSERT(MB), .RELEASE_GAP(GB), .WDOG_CYCLES(WB))
    dut_b (.clk(clk), .reset_in(rb), .bus(ifb.slave));

  always #5 clk = ~clk;
  always @(negedge ra) drop_a++;
  always @(negedge rb) drop_b++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_edge(input int d, input logic dropped, input logic rin,
                            input logic sw, input logic kick);
    int   done_edge, base;
    logic fire;
    fire = 1'b0;
    e[d]++;
    if (dropped || !rin) begin
      hi[d] = 0; rel[d] = -1; cause[d] = 1; lastk[d] = -1;
    end
    if (rin) begin
      if (hi[d] < 1000) hi[d]++;
      done_edge = rel[d] + (PN[d] - 1) * PG[d];
      if (WD_ON && rel[d] >= 0 && e[d] > done_edge) begin
        base = (lastk[d] > done_edge) ? lastk[d] : done_edge;
        if (kick) lastk[d] = e[d];
        else if (e[d] - base == PW[d]) fire = 1'b1;
      end
      if (hi[d] == S) rel[d] = e[d] + PM[d];
      else if (hi[d] > S && (sw || fire)) begin
        rel[d]   = e[d] + ((PM[d] > 1) ? PM[d] : 1);
        cause[d] = sw ? 2 : 3;
        lastk[d] = -1;
      end
    end
  endtask

  function automatic logic [2:0] exp_out(input int d);
    logic [2:0] v;
    v = '0;
    for (int k = 0; k < PN[d]; k++)
      if (rel[d] >= 0 && e[d] >= rel[d] + k * PG[d]) v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic exp_done(input int d);
    return rel[d] >= 0 && e[d] >= rel[d] + (PN[d] - 1) * PG[d];
  endfunction

  // advance n edges; model steps on each edge, outputs compared 1 ns later
  task automatic edges(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge(0, drop_a != seen_a, ra, ifa.sw_rst_req, ifa.wdog_kick);
      seen_a = drop_a;
      model_edge(1, drop_b != seen_b, rb, ifb.sw_rst_req, ifb.wdog_kick);
      seen_b = drop_b;
      #1;
      chk("a_reset_out", 32'(ifa.reset_out), 32'(exp_out(0)));
      chk("a_seq_done",  32'(ifa.seq_done),  32'(exp_done(0)));
      chk("a_rst_cause", 32'(ifa.rst_cause), cause[0]);
      chk("b_reset_out", 32'(ifb.reset_out), 32'(exp_out(1)));
      chk("b_seq_done",  32'(ifb.seq_done),  32'(exp_done(1)));
      chk("b_rst_cause", 32'(ifb.rst_cause), cause[1]);
    end
  endtask

  initial begin
    ra = 1'b1; rb = 1'b1;
    ifa.sw_rst_req = 1'b0; ifa.wdog_kick = 1'b1;
    ifb.sw_rst_req = 1'b0; ifb.wdog_kick = 1'b0;
    #2 ra = 1'b0; rb = 1'b0;
    #1;
    chk("lit_rst_a_out",   32'(ifa.reset_out), 0);
    chk("lit_rst_a_done",  32'(ifa.seq_done),  0);
    chk("lit_rst_a_cause", 32'(ifa.rst_cause), 1);
    chk("lit_rst_b_out",   32'(ifb.reset_out), 0);
    edges(2);
    #3 ra = 1'b1; rb = 1'b1;
    edges(1);  chk("lit_b_edge1", 32'(ifb.reset_out), 0);
    edges(1);  chk("lit_b_edge2", 32'(ifb.reset_out), 1);
               chk("lit_b_done2", 32'(ifb.seq_done), 1);
    edges(3);  chk("lit_a_edge5", 32'(ifa.reset_out), 0);
    edges(1);  chk("lit_a_edge6", 32'(ifa.reset_out), 1);
    edges(7);  chk("lit_a_edge13", 32'(ifa.reset_out), 1);
    edges(1);  chk("lit_a_edge14", 32'(ifa.reset_out), 3);
    edges(7);  chk("lit_a_done21", 32'(ifa.seq_done), 0);
    edges(1);  chk("lit_a_edge22", 32'(ifa.reset_out), 7);
               chk("lit_a_done22", 32'(ifa.seq_done), 1);
               chk("lit_a_cause22", 32'(ifa.rst_cause), 1);
    // 3 ns glitch on B's reset between edges
    #1 rb = 1'b0;
    #2 chk("lit_b_glitch", 32'(ifb.reset_out), 0);
    #1 rb = 1'b1;
    edges(1);  chk("lit_b_reedge1", 32'(ifb.reset_out), 0);
    edges(1);  chk("lit_b_reedge2", 32'(ifb.reset_out), 1);
    // single-cycle software reset from RUN
    ifa.sw_rst_req = 1'b1;
    edges(1);  ifa.sw_rst_req = 1'b0;
               chk("lit_sw_e_out",   32'(ifa.reset_out), 0);
               chk("lit_sw_e_cause", 32'(ifa.rst_cause), 2);
    edges(3);  chk("lit_sw_e3", 32'(ifa.reset_out), 0);
    edges(1);  chk("lit_sw_e4", 32'(ifa.reset_out), 1);
    edges(8);  chk("lit_sw_e12", 32'(ifa.reset_out), 3);
    edges(8);  chk("lit_sw_e20", 32'(ifa.reset_out), 7);
    // held software request for 10 cycles
    ifa.sw_rst_req = 1'b1;
    edges(9);  chk("lit_hold_e8", 32'(ifa.reset_out), 0);
    edges(1);  ifa.sw_rst_req = 1'b0;
    edges(3);  chk("lit_hold_e12", 32'(ifa.reset_out), 0);
    edges(1);  chk("lit_hold_e13", 32'(ifa.reset_out), 1);
    edges(2);
    // external reset mid-RELEASE, with a simultaneous software request
    #1 ra = 1'b0; ifa.sw_rst_req = 1'b1;
    #1 chk("lit_mid_out",   32'(ifa.reset_out), 0);
       chk("lit_mid_done",  32'(ifa.seq_done),  0);
       chk("lit_mid_cause", 32'(ifa.rst_cause), 1);
    edges(1);
    #3 ra = 1'b1;
    edges(2);  ifa.sw_rst_req = 1'b0;
               chk("lit_assert_ign_cause", 32'(ifa.rst_cause), 1);
    edges(3);  chk("lit_rerel_e5", 32'(ifa.reset_out), 0);
    edges(1);  chk("lit_rerel_e6", 32'(ifa.reset_out), 1);
    ifa.wdog_kick = 1'b0;
    edges(16); chk("lit_rerel_e22", 32'(ifa.reset_out), 7);
`ifdef RSTSEQ_WDOG_EN
    edges(15); chk("lit_wd_e37", 32'(ifa.reset_out), 7);
    edges(1);  chk("lit_wd_e38", 32'(ifa.reset_out), 0);
               chk("lit_wd_cause", 32'(ifa.rst_cause), 3);
    edges(20); chk("lit_wd_e58", 32'(ifa.reset_out), 7);
    for (int i = 0; i < 5; i++) begin
      ifa.wdog_kick = 1'b1;
      edges(1);
      ifa.wdog_kick = 1'b0;
      edges(9);
    end
    chk("lit_wd_kicked", 32'(ifa.reset_out), 7);
    edges(6);
    ifa.wdog_kick = 1'b1; ifa.sw_rst_req = 1'b1;
    edges(1);
    ifa.wdog_kick = 1'b0; ifa.sw_rst_req = 1'b0;
    chk("lit_wd_sw_out",   32'(ifa.reset_out), 0);
    chk("lit_wd_sw_cause", 32'(ifa.rst_cause), 2);
    edges(22);
`else
    edges(30);
    chk("lit_nowd_out",   32'(ifa.reset_out), 7);
    chk("lit_nowd_cause", 32'(ifa.rst_cause), 1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- Parametrised reset synchroniser and sequencer. Takes one asynchronous active-low reset and produces N_OUT active-low resets for the clk domain.
- Every output asserts asynchronously and releases synchronously through a SYNC_STAGES-deep chain.
- Outputs then release one after another, with a guaranteed minimum assertion time and a software-requested re-reset.
- Sits at the top of each clock domain and feeds per-subsystem resets, e.g. the capture path, then the FIFO, then the bus interface.

Parameters:
- SYNC_STAGES, 2, synchroniser depth, >=2.
- N_OUT, 3, number of sequenced reset outputs, >=1.
- MIN_ASSERT, 4, extra cycles all outputs stay low after the synchroniser releases, >=0.
- RELEASE_GAP, 8, cycles between successive output releases, >=1.
- WDOG_CYCLES, 65536, watchdog timeout in cycles; used only with the optional feature, >=2.

Ports:
- clk  in  1  domain clock.
- reset_in  in  1  asynchronous active-low master reset.
- sw_rst_req  in  1  synchronous to clk, active-high re-reset request.
- wdog_kick  in  1  synchronous to clk, watchdog service pulse.
- reset_out  out  N_OUT  active-low resets; bit 0 releases first.
- seq_done  out  1  high once every output has released.
- rst_cause  out  2  last reset source: 01 = external, 10 = software, 11 = watchdog.

Behaviour:
- Clocking and reset: clock is clk. Reset is reset_in, asynchronous, active-low.
- Values while reset_in is low:
  - reset_out = 0 (all bits), seq_done = 0, rst_cause = 01.
  - Synchroniser stages, FSM and all counters are cleared.
- Asynchronous assertion: reset_in falling forces the above values immediately, in any state and mid-sequence.
- Release timing after external reset:
  - Edge 1 is the first clk rising edge that samples reset_in high.
  - The synchroniser output rises at edge SYNC_STAGES.
  - reset_out[k] rises at edge SYNC_STAGES + MIN_ASSERT + k*RELEASE_GAP.
  - seq_done rises on the same edge as reset_out[N_OUT-1].
  - Example: SYNC_STAGES=2, MIN_ASSERT=0, N_OUT=1 releases at edge 2 (plain two-flop synchroniser).
- Once released, a reset_out bit stays high until the next reset event.
- FSM states:
  - ASSERT: synchroniser output low.
  - HOLD: counting MIN_ASSERT cycles (or SW_ASSERT after a software or watchdog reset).
  - RELEASE: index k with a gap counter.
  - RUN: all outputs released.
- FSM transitions:
  - ASSERT -> HOLD when the synchroniser output goes high.
  - HOLD -> RELEASE when the hold count expires.
  - RELEASE -> RUN after bit N_OUT-1 is released.
  - With MIN_ASSERT = 0, HOLD is zero-length; the timing formula still holds.
- Software reset:
  - sw_rst_req is acted on when sampled high at edge E in HOLD, RELEASE or RUN. A high sample in ASSERT is ignored.
  - At edge E: all reset_out bits go low, seq_done goes low, rst_cause becomes 10, and the FSM enters HOLD.
  - reset_out[k] then rises at edge E + SW_ASSERT + k*RELEASE_GAP, where SW_ASSERT = max(MIN_ASSERT, 1).
  - If sw_rst_req is still high on later edges, the sequence restarts from each such edge. Outputs stay low while the request is held.
  - A software request in the same cycle that reset_in goes low: reset_in wins, and rst_cause = 01.
- Counter widths are sized by $clog2 of the largest count plus 1. No wrap-around is possible inside a sequence.
- rst_cause changes only on a new reset event and otherwise holds its value.

Optional Feature:
- Macro: RSTSEQ_WDOG_EN.
- When defined:
  - A watchdog counter runs only while the FSM is in RUN.
  - The counter clears to 0 on any cycle with wdog_kick = 1, and on leaving RUN.
  - When it reaches WDOG_CYCLES-1 without a kick, the next edge performs the software-reset sequence, with rst_cause = 11.
  - sw_rst_req takes priority over the watchdog in the same cycle (cause 10).
- When not defined: wdog_kick is ignored, no watchdog counter is built, and rst_cause never reads 11.

Test Plan:
- Default params; deassert reset_in between edges -> reset_out goes 000 -> 001 at edge 6 -> 011 at edge 14 -> 111 at edge 22; seq_done rises at edge 22; rst_cause = 01.
- SYNC_STAGES=2, MIN_ASSERT=0, N_OUT=1 -> reset_out[0] rises at edge 2. Also pulse reset_in low for 3 ns between edges -> output goes low immediately and the 2-edge release repeats.
- RUN state, sw_rst_req high for 1 cycle at edge E -> reset_out = 000 at E; bit 0 rises at E+4, bit 1 at E+12, bit 2 at E+20; rst_cause = 10.
- sw_rst_req high for 10 cycles starting at E -> outputs low throughout; bit 0 rises at E+9+4; reset_in dropped mid-RELEASE -> all outputs low asynchronously and rst_cause = 01.
- RSTSEQ_WDOG_EN with WDOG_CYCLES=16:
  - No kick -> re-reset 16 cycles after seq_done rises, with rst_cause = 11.
  - Kick every 10 cycles -> no re-reset.
  - Kick and sw_rst_req together in the timeout cycle -> rst_cause = 10.
